axi_reflection_lite_slave: RTL and testbench
============================================

AXI_REFLECTION_LITE_SLAVE -- requirements
Module: axi_reflection_lite_slave

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 5: byte-address width; 8 word slots.
REQ-002 SHALL have parameter C_ID_VALUE, default 32'hA11E_0001: constant returned by the ID register.
REQ-003 SHALL have port ACLK, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port ARESETN, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have the write-address ports AWADDR (input, C_ADDR_WIDTH) and AWPROT (input, 3, ignored), AWVALID (input, 1) and AWREADY (output, 1).
REQ-006 SHALL have the write-data ports WDATA (input, 32), WSTRB (input, 4) and WVALID (input, 1), with WREADY (output, 1).
REQ-007 SHALL have the write-response ports BRESP (output, 2) and BVALID (output, 1), with BREADY (input, 1).
REQ-008 SHALL have the read-address ports ARADDR (input, C_ADDR_WIDTH) and ARPROT (input, 3, ignored), ARVALID (input, 1) and ARREADY (output, 1).
REQ-009 SHALL have the read-data ports RDATA (output, 32), RRESP (output, 2) and RVALID (output, 1), with RREADY (input, 1).

Function
REQ-010 SHALL decode word index = ADDR[4:2] and ignore ADDR[1:0]:
- 0-3: REG0-REG3, read/write.
- 4: WCNT, read-only count of committed OKAY writes, 32-bit wrapping.
- 5: ID, read-only, C_ID_VALUE.
- 6-7: unmapped.
REQ-011 SHALL give the AW and W channels each a single-entry holding buffer; AWREADY = AW buffer empty; WREADY = W buffer empty; AW and W accepted independently, in either order or in the same cycle.
REQ-012 SHALL commit a write on the first edge where both buffers are full and BVALID=0, at which edge the buffers empty and BVALID rises; latency from the later of the AW/W handshakes to BVALID = 1 cycle.
REQ-013 SHALL update at commit only the REG bytes whose WSTRB bit is set; WSTRB=4'b0000 leaves data unchanged but is still OKAY and counted.
REQ-014 SHALL respond to writes to index 4-5 with BRESP=SLVERR (2'b10) and 6-7 with DECERR (2'b11), and such writes change no state and do not increment WCNT.
REQ-015 SHALL hold BVALID and BRESP stable until the BVALID&&BREADY edge; BVALID falls there unless a new commit occurs on the same edge, in which case BVALID stays 1 with the new BRESP.
REQ-016 SHALL drive ARREADY = !RVALID; on the ARVALID&&ARREADY edge, capture RDATA and RRESP and set RVALID=1.
REQ-017 SHALL return RRESP=OKAY for index 0-5; index 6-7 SHALL return DECERR with RDATA=0.
REQ-018 SHALL hold RDATA, RRESP and RVALID stable until the RVALID&&RREADY edge; RVALID clears there, and the next AR is accepted one cycle later, giving a maximum of 1 read per 2 cycles.
REQ-019 SHALL, when an AR capture and a write commit to the same word fall on the same edge, return the pre-commit value; the new value is visible from the next read.
REQ-020 SHALL operate read and write paths fully independently, with no ordering between them.
REQ-021 SHALL keep an accepted but uncommitted AW or W buffered indefinitely while the other channel is absent.

Reset
REQ-022 SHALL, while ARESETN=0, asynchronously force the following:
- AWREADY=0, WREADY=0, BVALID=0, BRESP=0.
- ARREADY=0, RVALID=0, RRESP=0, RDATA=0.
- REG0-REG3=0, WCNT=0, both buffers empty.
REQ-023 SHALL raise AWREADY, WREADY and ARREADY on the first rising edge after ARESETN deasserts.
REQ-024 SHALL discard any in-flight transaction on reset assertion mid-operation: no commit, no response after release.

Verification
REQ-025 Scenario: write 1,2,3,4 to 0x0,0x4,0x8,0xC (WSTRB=F), then read the same four addresses -> BRESP=OKAY each; reads return 1,2,3,4 with OKAY; WCNT (0x10) reads 4.
REQ-026 Scenario: W presented 3 cycles before AW, BREADY held low 5 cycles -> WREADY drops after the W handshake; BVALID rises 1 cycle after the AW handshake and stays 1 with BRESP stable until BREADY.
REQ-027 Scenario: REG1=32'h11223344, then write 32'hAABBCCDD with WSTRB=4'b0101 -> REG1 reads 32'h11BB33DD.
REQ-028 Scenario: write 0x14 and read 0x18 -> BRESP=SLVERR with ID still reading C_ID_VALUE; RRESP=DECERR with RDATA=0; WCNT unchanged.
REQ-029 Scenario: an AR to 0x0 accepted on the same edge as a commit of 32'h5 to REG0 (old value 32'h1) -> RDATA=32'h1; the next read returns 32'h5.
REQ-030 Scenario: ARESETN pulsed low while BVALID=1 and AW is buffered -> all outputs 0 during reset; no BVALID after release; REG0-REG3 and WCNT read 0.

Source files
------------

// File: rtl/axi_reflection_lite_slave_if.sv
// AXI4-Lite bus bundle for the reflection slave: the five channels, with
// master and slave views.
interface axi_reflection_lite_slave_if #(
  parameter int unsigned C_ADDR_WIDTH = 5
);
  logic [C_ADDR_WIDTH-1:0] AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [31:0]             WDATA;
  logic [3:0]              WSTRB;
  logic                    WVALID;
  logic                    WREADY;

  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  logic [C_ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [31:0]             RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID,    output WREADY,
    output BRESP, BVALID,           input  BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID,    input  RREADY
  );

  modport master (
    output AWADDR, AWPROT, AWVALID, input  AWREADY,
    output WDATA, WSTRB, WVALID,    input  WREADY,
    input  BRESP, BVALID,           output BREADY,
    output ARADDR, ARPROT, ARVALID, input  ARREADY,
    input  RDATA, RRESP, RVALID,    output RREADY
  );
endinterface

// File: rtl/axi_reflection_lite_slave.sv
// AXI4-Lite slave with four byte-writable registers, a committed-write counter
// and a constant ID word; AW and W are each held in a one-entry buffer.
module axi_reflection_lite_slave #(
  parameter int unsigned C_ADDR_WIDTH = 5,
  parameter logic [31:0] C_ID_VALUE   = 32'hA11E_0001
) (
  input logic                        ACLK,
  input logic                        ARESETN,
  axi_reflection_lite_slave_if.slave bus
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic        out_of_reset;
  logic        aw_full;
  logic [2:0]  aw_idx;
  logic        w_full;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        rvalid;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic [31:0] regs [4];
  logic [31:0] wcnt;

  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        commit;
  logic        commit_to_reg;
  logic [1:0]  commit_resp;
  logic [2:0]  ar_idx;
  logic [31:0] rd_value;
  logic [1:0]  rd_resp;
  logic        unused_bits;

  // Ready lines stay low until the first edge after reset release.
  assign bus.AWREADY = out_of_reset && !aw_full;
  assign bus.WREADY  = out_of_reset && !w_full;
  assign bus.ARREADY = out_of_reset && !rvalid;
  assign bus.BVALID  = bvalid;
  assign bus.BRESP   = bresp;
  assign bus.RVALID  = rvalid;
  assign bus.RRESP   = rresp;
  assign bus.RDATA   = rdata;

  assign aw_hs  = bus.AWVALID && bus.AWREADY;
  assign w_hs   = bus.WVALID && bus.WREADY;
  assign ar_hs  = bus.ARVALID && bus.ARREADY;
  assign ar_idx = bus.ARADDR[4:2];

  // A commit may reuse the response slot on the same edge it is acknowledged.
  assign commit        = aw_full && w_full && (!bvalid || bus.BREADY);
  assign commit_to_reg = commit && !aw_idx[2];

  assign unused_bits = ^{bus.AWPROT, bus.ARPROT, bus.AWADDR[1:0], bus.ARADDR[1:0]};

  always_comb begin
    commit_resp = RESP_DECERR;
    case (aw_idx)
      3'd0, 3'd1, 3'd2, 3'd3: commit_resp = RESP_OKAY;
      3'd4, 3'd5:             commit_resp = RESP_SLVERR;
      default:                commit_resp = RESP_DECERR;
    endcase
  end

  always_comb begin
    rd_value = '0;
    rd_resp  = RESP_OKAY;
    case (ar_idx)
      3'd0, 3'd1, 3'd2, 3'd3: rd_value = regs[ar_idx[1:0]];
      3'd4:                   rd_value = wcnt;
      3'd5:                   rd_value = C_ID_VALUE;
      default:                rd_resp  = RESP_DECERR;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full <= 1'b0;
      aw_idx  <= '0;
    end else if (commit) begin
      aw_full <= 1'b0;
    end else if (aw_hs) begin
      aw_full <= 1'b1;
      aw_idx  <= bus.AWADDR[4:2];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_full <= 1'b0;
      w_data <= '0;
      w_strb <= '0;
    end else if (commit) begin
      w_full <= 1'b0;
    end else if (w_hs) begin
      w_full <= 1'b1;
      w_data <= bus.WDATA;
      w_strb <= bus.WSTRB;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else if (commit) begin
      bvalid <= 1'b1;
      bresp  <= commit_resp;
    end else if (bvalid && bus.BREADY) begin
      bvalid <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
      wcnt <= '0;
    end else if (commit_to_reg) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) begin
          regs[aw_idx[1:0]][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
      wcnt <= wcnt + 32'd1;
    end
  end

  // Read data is sampled from pre-edge state, so a same-edge commit is not seen.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rresp  <= rd_resp;
      rdata  <= rd_value;
    end else if (rvalid && bus.RREADY) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_reflection_lite_slave.sv
// Directed self-checking bench for axi_reflection_lite_slave: register
// access, strobes, error responses, channel skew, read/commit collision, reset.
module tb_axi_reflection_lite_slave;

  localparam logic [31:0] ID_VALUE = 32'hA11E_0001;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  int   check_count = 0;
  int   error_count = 0;

  axi_reflection_lite_slave_if #(.C_ADDR_WIDTH(5)) bus ();

  axi_reflection_lite_slave #(
    .C_ADDR_WIDTH(5),
    .C_ID_VALUE  (ID_VALUE)
  ) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .bus    (bus)
  );

  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'd0);
    checkOutput({tag, "_b"}, {29'd0, bus.BVALID, bus.BRESP}, 32'd0);
    checkOutput({tag, "_r"}, {29'd0, bus.RVALID, bus.RRESP}, 32'd0);
    checkOutput({tag, "_rdata"}, bus.RDATA, 32'd0);
  endtask

  // All transaction tasks start and end 1 time unit after a rising edge.
  task automatic writeWord(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_done, w_done, aw_hs, w_hs, got;
    int   cycles;
    aw_done = 1'b0;
    w_done  = 1'b0;
    bus.AWADDR  = addr;
    bus.AWVALID = 1'b1;
    bus.WDATA   = data;
    bus.WSTRB   = strb;
    bus.WVALID  = 1'b1;
    bus.BREADY  = 1'b0;
    cycles = 0;
    while (!(aw_done && w_done) && cycles < 20) begin
      @(negedge ACLK);
      aw_hs = bus.AWVALID && bus.AWREADY;
      w_hs  = bus.WVALID && bus.WREADY;
      @(posedge ACLK); #1;
      if (aw_hs) begin aw_done = 1'b1; bus.AWVALID = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; bus.WVALID  = 1'b0; end
      cycles++;
    end
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    checkOutput("wr_handshake", {30'd0, aw_done, w_done}, 32'd3);
    bus.BREADY = 1'b1;
    got    = 1'b0;
    resp   = 2'bxx;
    cycles = 0;
    while (!got && cycles < 20) begin
      @(negedge ACLK);
      if (bus.BVALID) begin got = 1'b1; resp = bus.BRESP; end
      @(posedge ACLK); #1;
      cycles++;
    end
    bus.BREADY = 1'b0;
    checkOutput("wr_bvalid", {31'd0, got}, 32'd1);
  endtask

  task automatic readWord(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic done, hs, got;
    int   cycles;
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    bus.RREADY  = 1'b0;
    done   = 1'b0;
    cycles = 0;
    while (!done && cycles < 20) begin
      @(negedge ACLK);
      hs = bus.ARVALID && bus.ARREADY;
      @(posedge ACLK); #1;
      if (hs) begin done = 1'b1; bus.ARVALID = 1'b0; end
      cycles++;
    end
    bus.ARVALID = 1'b0;
    checkOutput("rd_handshake", {31'd0, done}, 32'd1);
    bus.RREADY = 1'b1;
    got    = 1'b0;
    data   = 'x;
    resp   = 2'bxx;
    cycles = 0;
    while (!got && cycles < 20) begin
      @(negedge ACLK);
      if (bus.RVALID) begin got = 1'b1; data = bus.RDATA; resp = bus.RRESP; end
      @(posedge ACLK); #1;
      cycles++;
    end
    bus.RREADY = 1'b0;
    checkOutput("rd_rvalid", {31'd0, got}, 32'd1);
  endtask

  task automatic expectRead(input string tag, input logic [4:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [31:0] data;
    logic [1:0]  resp;
    readWord(addr, data, resp);
    checkOutput({tag, "_data"}, data, exp_data);
    checkOutput({tag, "_resp"}, {30'd0, resp}, {30'd0, exp_resp});
  endtask

  task automatic expectWrite(input string tag, input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp);
    logic [1:0] resp;
    writeWord(addr, data, strb, resp);
    checkOutput({tag, "_bresp"}, {30'd0, resp}, {30'd0, exp_resp});
  endtask

  task automatic applyStimulus();
    logic ok;
    int   cycles;

    // Reset state and first edge after release
    #2;
    checkResetOutputs("por");
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    checkOutput("ready_before_edge", {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'd0);
    @(posedge ACLK); #1;
    checkOutput("ready_after_edge", {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'd7);

    // Basic write/read of all four registers
    for (int i = 0; i < 4; i++) begin
      expectWrite($sformatf("wr_reg%0d", i), 5'(4 * i), 32'(i + 1), 4'hF, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      expectRead($sformatf("rd_reg%0d", i), 5'(4 * i), 32'(i + 1), 2'b00);
    end
    expectRead("wcnt_4", 5'h10, 32'd4, 2'b00);

    // Byte strobes and low address bits ignored
    expectWrite("reg1_full", 5'h04, 32'h1122_3344, 4'hF, 2'b00);
    expectWrite("reg1_strb", 5'h04, 32'hAABB_CCDD, 4'b0101, 2'b00);
    expectRead("reg1_merge", 5'h07, 32'h11BB_33DD, 2'b00);
    expectWrite("reg3_nostrb", 5'h0C, 32'hFFFF_FFFF, 4'b0000, 2'b00);
    expectRead("reg3_keep", 5'h0C, 32'd4, 2'b00);
    expectRead("wcnt_7", 5'h10, 32'd7, 2'b00);

    // Error responses
    expectWrite("wr_id", 5'h14, 32'hDEAD_BEEF, 4'hF, 2'b10);
    expectWrite("wr_wcnt", 5'h10, 32'h0000_0000, 4'hF, 2'b10);
    expectWrite("wr_unmapped", 5'h1C, 32'h1234_5678, 4'hF, 2'b11);
    expectRead("rd_id", 5'h14, ID_VALUE, 2'b00);
    expectRead("rd_unmapped", 5'h18, 32'd0, 2'b11);
    expectRead("wcnt_after_err", 5'h10, 32'd7, 2'b00);

    // W three cycles ahead of AW, response held with BREADY low
    bus.WDATA  = 32'hCAFE_F00D;
    bus.WSTRB  = 4'hF;
    bus.WVALID = 1'b1;
    @(negedge ACLK);
    checkOutput("skew_wready", {31'd0, bus.WREADY}, 32'd1);
    @(posedge ACLK); #1;
    bus.WVALID = 1'b0;
    @(negedge ACLK);
    checkOutput("skew_w_held", {30'd0, bus.WREADY, bus.BVALID}, 32'd0);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    bus.AWADDR  = 5'h08;
    bus.AWVALID = 1'b1;
    @(negedge ACLK);
    checkOutput("skew_pre_aw", {30'd0, bus.AWREADY, bus.BVALID}, 32'd2);
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
    @(negedge ACLK);
    checkOutput("skew_bvalid_early", {31'd0, bus.BVALID}, 32'd0);
    @(posedge ACLK); #1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      if (!(bus.BVALID && bus.BRESP == 2'b00 && !bus.WREADY == 1'b0)) ok = 1'b0;
      @(posedge ACLK); #1;
    end
    checkOutput("skew_b_hold", {31'd0, ok}, 32'd1);
    bus.BREADY = 1'b1;
    @(negedge ACLK);
    checkOutput("skew_b_before_ack", {31'd0, bus.BVALID}, 32'd1);
    @(posedge ACLK); #1;
    bus.BREADY = 1'b0;
    @(negedge ACLK);
    checkOutput("skew_b_after_ack", {29'd0, bus.BVALID, bus.AWREADY, bus.WREADY}, 32'd3);
    @(posedge ACLK); #1;
    expectRead("skew_reg2", 5'h08, 32'hCAFE_F00D, 2'b00);

    // AR captured on the same edge as a commit to the same word
    bus.AWADDR  = 5'h00;
    bus.AWVALID = 1'b1;
    bus.WDATA   = 32'h0000_0005;
    bus.WSTRB   = 4'hF;
    bus.WVALID  = 1'b1;
    @(negedge ACLK);
    checkOutput("coll_ready", {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'd7);
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    bus.ARADDR  = 5'h00;
    bus.ARVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.ARVALID = 1'b0;
    @(negedge ACLK);
    checkOutput("coll_rdata", bus.RDATA, 32'h1);
    checkOutput("coll_flags", {28'd0, bus.RVALID, bus.BVALID, bus.ARREADY, bus.RRESP == 2'b00}, 32'hD);
    bus.RREADY = 1'b1;
    bus.BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.RREADY = 1'b0;
    bus.BREADY = 1'b0;
    @(negedge ACLK);
    checkOutput("coll_cleared", {29'd0, bus.RVALID, bus.BVALID, bus.ARREADY}, 32'd1);
    @(posedge ACLK); #1;
    expectRead("coll_next", 5'h00, 32'h5, 2'b00);
    expectRead("wcnt_9", 5'h10, 32'd9, 2'b00);

    // Reset while a response is pending and an AW is buffered
    bus.AWADDR  = 5'h04;
    bus.AWVALID = 1'b1;
    bus.WDATA   = 32'h0000_0099;
    bus.WVALID  = 1'b1;
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    @(posedge ACLK); #1;
    bus.AWADDR  = 5'h0C;
    bus.AWVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
    @(negedge ACLK);
    checkOutput("pre_rst_state", {30'd0, bus.BVALID, bus.AWREADY}, 32'd2);
    ARESETN = 1'b0;
    #1;
    checkResetOutputs("mid_rst");
    @(posedge ACLK); #1;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    bus.WDATA  = 32'h0000_0077;
    bus.WSTRB  = 4'hF;
    bus.WVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.WVALID = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge ACLK);
      if (bus.BVALID || bus.RVALID) ok = 1'b0;
      @(posedge ACLK); #1;
    end
    checkOutput("post_rst_no_resp", {31'd0, ok}, 32'd1);
    @(negedge ACLK);
    checkOutput("w_still_held", {31'd0, bus.WREADY}, 32'd0);
    @(posedge ACLK); #1;
    for (int i = 0; i < 4; i++) begin
      expectRead($sformatf("rst_reg%0d", i), 5'(4 * i), 32'd0, 2'b00);
    end
    expectRead("rst_wcnt", 5'h10, 32'd0, 2'b00);

    // Late AW completes the W held across the idle period
    bus.AWADDR  = 5'h00;
    bus.AWVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
    bus.BREADY  = 1'b1;
    ok     = 1'b0;
    cycles = 0;
    while (!ok && cycles < 20) begin
      @(negedge ACLK);
      if (bus.BVALID) ok = 1'b1;
      @(posedge ACLK); #1;
      cycles++;
    end
    bus.BREADY = 1'b0;
    checkOutput("late_aw_bvalid", {31'd0, ok}, 32'd1);
    expectRead("late_aw_reg0", 5'h00, 32'h77, 2'b00);
    expectRead("late_aw_wcnt", 5'h10, 32'd1, 2'b00);
  endtask

  initial begin
    bus.AWADDR  = '0;
    bus.AWPROT  = '0;
    bus.AWVALID = 1'b0;
    bus.WDATA   = '0;
    bus.WSTRB   = '0;
    bus.WVALID  = 1'b0;
    bus.BREADY  = 1'b0;
    bus.ARADDR  = '0;
    bus.ARPROT  = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b0;
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
